// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control: Moore main FSM, ALU decoder and immediate-type decoder.
// Outputs decode from the state register in the same cycle; FETCH/MEMREAD/MEMWRITE stall on mem_ready when WAIT_MEM=1.
module riscv_multicycle_ctrl #(
    parameter int ALUCTRL_W      = 4,
    parameter bit SUPPORT_SHIFTS = 1'b1,
    parameter bit WAIT_MEM       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_go;
    logic   shift_op;
    aluop_t alu_op;
    logic [3:0] alu_code;
    logic   pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;

    assign mem_go   = mem_ready | !WAIT_MEM;
    assign shift_op = (funct3[1:0] == 2'b01);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:   state_d = (!SUPPORT_SHIFTS && shift_op) ? S_TRAP : S_EXECR;
                    OP_I:   state_d = (!SUPPORT_SHIFTS && shift_op) ? S_TRAP : S_EXECI;
                    OP_BR:  state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL: state_d = S_JAL;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_go) state_d = S_FETCH;
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = ALUOP_ADD;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_write_raw = mem_go;
                ir_write_raw = mem_go;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write_raw = 1'b1;
            S_BRANCH: begin
                alu_src_a    = 2'b10;
                alu_op       = ALUOP_SUB;
                pc_write_raw = zero ^ funct3[0];
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked combinationally so nothing is written while reset is held.
    assign pc_write  = pc_write_raw  & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign illegal   = illegal_q;
    assign state_o   = state_q;

    always_comb begin
        alu_code = 4'b0000;
        unique case (alu_op)
            ALUOP_SUB: alu_code = 4'b0001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: alu_code = (funct7b5 & op[5]) ? 4'b0001 : 4'b0000;
                    3'b001: alu_code = SUPPORT_SHIFTS ? 4'b0111 : 4'b0000;
                    3'b010: alu_code = 4'b0101;
                    3'b011: alu_code = 4'b0110;
                    3'b100: alu_code = 4'b0100;
                    3'b101: alu_code = !SUPPORT_SHIFTS ? 4'b0000 :
                                       (funct7b5 ? 4'b1001 : 4'b1000);
                    3'b110: alu_code = 4'b0011;
                    default: alu_code = 4'b0010;
                endcase
            end
            default: alu_code = 4'b0000;
        endcase
        alu_control      = '0;
        alu_control[3:0] = alu_code;
    end

    always_comb begin
        case (op)
            OP_STORE: imm_src = 2'b01;
            OP_BR:    imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl; a second instance runs with shifts disabled.
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0] alu_control, state_o;

    logic       n_pc_write, n_adr_src, n_mem_write, n_ir_write, n_reg_write, n_illegal;
    logic [1:0] n_result_src, n_alu_src_a, n_alu_src_b, n_imm_src;
    logic [3:0] n_alu_control, n_state_o;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .state_o(state_o)
    );

    riscv_multicycle_ctrl #(.ALUCTRL_W(4), .SUPPORT_SHIFTS(1'b0), .WAIT_MEM(1'b1)) dut_ns (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(n_pc_write), .adr_src(n_adr_src),
        .mem_write(n_mem_write), .ir_write(n_ir_write), .reg_write(n_reg_write),
        .result_src(n_result_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
        .imm_src(n_imm_src), .alu_control(n_alu_control), .illegal(n_illegal), .state_o(n_state_o)
    );

    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic advance(input int n);
        mem_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_state got state=%0d illegal=%b exp state=0 illegal=0", state_o, illegal);
        end
        checks++;
        if (pc_write !== 1'b0 || ir_write !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("FAIL reset_enables got pc=%b ir=%b rw=%b mw=%b exp all 0", pc_write, ir_write, reg_write, mem_write);
        end
        checks++;
        if (alu_src_b !== 2'b10 || result_src !== 2'b10 || alu_src_a !== 2'b00 || adr_src !== 1'b0) begin
            errors++; $display("FAIL reset_fetch_decode got srcb=%b res=%b srca=%b adr=%b exp 10 10 00 0", alu_src_b, result_src, alu_src_a, adr_src);
        end
        do_reset();
    endtask

    task automatic test_lw_wait();
        int exp_st[12] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic rdy[12]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0};
        int irw = 0;
        do_reset();
        op = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i])) begin
                errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]);
            end
            checks++;
            if (reg_write !== (exp_st[i] == 4)) begin
                errors++; $display("FAIL lw_reg_write[%0d] got=%b exp=%b", i, reg_write, exp_st[i] == 4);
            end
            if (ir_write === 1'b1) irw++;
            @(negedge clk);
        end
        checks++;
        if (irw != 1) begin
            errors++; $display("FAIL lw_ir_write_pulses got=%0d exp=1", irw);
        end
    endtask

    task automatic test_reset_mid_memwrite();
        do_reset();
        op = OP_STORE; funct3 = 3'b010;
        advance(3);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd5 || mem_write !== 1'b1 || adr_src !== 1'b1) begin
            errors++; $display("FAIL sw_memwrite got state=%0d mw=%b adr=%b exp 5 1 1", state_o, mem_write, adr_src);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd5 || mem_write !== 1'b1) begin
            errors++; $display("FAIL sw_hold got state=%0d mw=%b exp 5 1", state_o, mem_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || mem_write !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL async_reset got state=%0d mw=%b ill=%b exp 0 0 0", state_o, mem_write, illegal);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b0 || ir_write !== 1'b0) begin
            errors++; $display("FAIL reset_mask got pc=%b ir=%b exp 0 0", pc_write, ir_write);
        end
        do_reset();
    endtask

    task automatic test_alu_decode();
        logic [2:0] f3[11]  = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111, 3'b000};
        logic       f7[11]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [6:0] opc[11] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_I};
        logic [3:0] ex[11]  = '{4'b0000, 4'b0001, 4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0010, 4'b0000};
        logic [3:0] exp_state;
        for (int i = 0; i < 11; i++) begin
            do_reset();
            op = opc[i]; funct3 = f3[i]; funct7b5 = f7[i];
            exp_state = (opc[i] == OP_R) ? 4'd6 : 4'd7;
            advance(2);
            #1;
            checks++;
            if (state_o !== exp_state || alu_control !== ex[i] || alu_src_a !== 2'b10) begin
                errors++; $display("FAIL alu_decode[%0d] got state=%0d alu=%b srca=%b exp state=%0d alu=%b srca=10", i, state_o, alu_control, alu_src_a, exp_state, ex[i]);
            end
            @(negedge clk);
            checks++;
            if (state_o !== 4'd8 || reg_write !== 1'b1 || result_src !== 2'b00) begin
                errors++; $display("FAIL aluwb[%0d] got state=%0d rw=%b res=%b exp 8 1 00", i, state_o, reg_write, result_src);
            end
        end
    endtask

    task automatic test_srai_no_shift();
        do_reset();
        op = OP_I; funct3 = 3'b101; funct7b5 = 1'b1;
        advance(2);
        #1;
        checks++;
        if (state_o !== 4'd7 || alu_control !== 4'b1001 || alu_src_b !== 2'b01) begin
            errors++; $display("FAIL srai got state=%0d alu=%b srcb=%b exp 7 1001 01", state_o, alu_control, alu_src_b);
        end
        checks++;
        if (n_state_o !== 4'd11 || n_illegal !== 1'b1) begin
            errors++; $display("FAIL srai_noshift_trap got state=%0d ill=%b exp 11 1", n_state_o, n_illegal);
        end
        op = OP_R; funct3 = 3'b000;
        advance(5);
        #1;
        checks++;
        if (n_state_o !== 4'd11 || n_illegal !== 1'b1 || n_pc_write !== 1'b0 || n_ir_write !== 1'b0) begin
            errors++; $display("FAIL trap_sticky got state=%0d ill=%b pc=%b ir=%b exp 11 1 0 0", n_state_o, n_illegal, n_pc_write, n_ir_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (n_state_o !== 4'd0 || n_illegal !== 1'b0) begin
            errors++; $display("FAIL trap_clear got state=%0d ill=%b exp 0 0", n_state_o, n_illegal);
        end
        do_reset();
    endtask

    task automatic test_branch();
        do_reset();
        op = OP_BR; funct3 = 3'b001; funct7b5 = 1'b0; zero = 1'b0;
        advance(2);
        #1;
        checks++;
        if (state_o !== 4'd9 || alu_control !== 4'b0001 || imm_src !== 2'b10 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
            errors++; $display("FAIL branch_state got state=%0d alu=%b imm=%b srca=%b srcb=%b exp 9 0001 10 10 00", state_o, alu_control, imm_src, alu_src_a, alu_src_b);
        end
        checks++;
        if (pc_write !== 1'b1) begin errors++; $display("FAIL bne_taken got pc_write=%b exp=1", pc_write); end
        zero = 1'b1; #1;
        checks++;
        if (pc_write !== 1'b0) begin errors++; $display("FAIL bne_not_taken got pc_write=%b exp=0", pc_write); end
        funct3 = 3'b000; #1;
        checks++;
        if (pc_write !== 1'b1) begin errors++; $display("FAIL beq_taken got pc_write=%b exp=1", pc_write); end
        zero = 1'b0; #1;
        checks++;
        if (pc_write !== 1'b0) begin errors++; $display("FAIL beq_not_taken got pc_write=%b exp=0", pc_write); end
        @(negedge clk);
        checks++;
        if (state_o !== 4'd0) begin errors++; $display("FAIL branch_return got state=%0d exp=0", state_o); end
        do_reset();
        funct3 = 3'b100;
        advance(2);
        #1;
        checks++;
        if (state_o !== 4'd11 || illegal !== 1'b1) begin
            errors++; $display("FAIL bad_branch_funct3 got state=%0d ill=%b exp 11 1", state_o, illegal);
        end
    endtask

    task automatic test_jal();
        do_reset();
        op = OP_JAL; funct3 = 3'b000;
        advance(2);
        #1;
        checks++;
        if (state_o !== 4'd10 || pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || imm_src !== 2'b11 || reg_write !== 1'b0) begin
            errors++; $display("FAIL jal got state=%0d pc=%b srca=%b srcb=%b imm=%b rw=%b exp 10 1 01 10 11 0", state_o, pc_write, alu_src_a, alu_src_b, imm_src, reg_write);
        end
    endtask

    task automatic test_illegal_op();
        do_reset();
        op = 7'b1111111;
        advance(1);
        #1;
        checks++;
        if (state_o !== 4'd1 || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_decode got state=%0d ill=%b exp 1 0", state_o, illegal);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state_o !== 4'd11 || illegal !== 1'b1 || pc_write !== 1'b0 || ir_write !== 1'b0 ||
                reg_write !== 1'b0 || mem_write !== 1'b0) begin
                errors++; $display("FAIL trap_cycle[%0d] got state=%0d ill=%b pc=%b ir=%b rw=%b mw=%b exp 11 1 0 0 0 0", i, state_o, illegal, pc_write, ir_write, reg_write, mem_write);
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_lw_wait();
        test_reset_mid_memwrite();
        test_alu_decode();
        test_srai_no_shift();
        test_branch();
        test_jal();
        test_illegal_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Next-generation control unit for the multicycle RV32I datapath.
- Combines a Moore main FSM, a generalised ALU decoder and an instruction-type immediate decoder.
- Generalised ALU decoder: parametrised ALUControl width, optional shifts, xor and sltu.
- Adds memory wait handshake, bne support and a sticky illegal-instruction trap.
- Sits between the instruction register and the datapath muxes/enables.

Parameters:
ALUCTRL_W, 4, ALUControl width; must be >=4; upper bits beyond bit 3 driven 0.
SUPPORT_SHIFTS, 1, 1 = decode sll/srl/sra; 0 = funct3 001/101 on R/I types trap.
WAIT_MEM, 1, 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = each state lasts exactly one cycle and mem_ready is ignored.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
op  in  7  instruction opcode.
funct3  in  3  instruction funct3.
funct7b5  in  1  instruction bit 30.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory access completes this cycle.
pc_write  out  1  PC register enable.
adr_src  out  1  0 = PC, 1 = ALU result register.
mem_write  out  1  data memory write enable.
ir_write  out  1  instruction register enable.
reg_write  out  1  register file write enable.
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1.
alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4.
imm_src  out  2  00 I, 01 S, 10 B, 11 J.
alu_control  out  ALUCTRL_W  ALU operation.
illegal  out  1  sticky illegal-instruction flag.
state_o  out  4  current state encoding, for debug.

Behaviour:
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11
- Reset (async, rst_n=0): state=FETCH, illegal=0.
  - While rst_n=0, pc_write, ir_write, reg_write and mem_write are forced 0.
  - All other outputs follow FETCH decode.
- Transitions:
  - FETCH->DECODE when (mem_ready | !WAIT_MEM).
  - DECODE on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other -> TRAP
  - Also DECODE->TRAP for: branch funct3 not in {000,001}; SUPPORT_SHIFTS=0 with R/I funct3 in {001,101}.
  - MEMADR -> MEMREAD for op 0000011, else MEMWRITE.
  - MEMREAD->MEMWB and MEMWRITE->FETCH, each gated by (mem_ready | !WAIT_MEM); otherwise hold.
  - MEMWB, ALUWB, BRANCH, JAL -> FETCH.
  - EXECR and EXECI -> ALUWB.
  - TRAP holds until reset; illegal=1 from the first TRAP cycle.
- Outputs are Moore from state; every output not listed below is 0.
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, ALUOp=add.
    - ir_write=1 and pc_write=1 only in the cycle FETCH exits.
  - DECODE: alu_src_a=01, alu_src_b=01, ALUOp=add.
  - MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=add.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1 on every cycle held.
  - EXECR: alu_src_a=10, alu_src_b=00, ALUOp=funct.
  - EXECI: alu_src_a=10, alu_src_b=01, ALUOp=funct.
  - ALUWB: result_src=00, reg_write=1.
  - BRANCH: alu_src_a=10, alu_src_b=00, ALUOp=sub, result_src=00.
    - pc_write = zero ^ funct3[0] (beq/bne).
  - JAL: alu_src_a=01, alu_src_b=10, result_src=00, ALUOp=add, pc_write=1.
  - TRAP: all enables 0.
- ALU decode (funct mode), funct3 ->
  - 000: add 0000; sub 0001 when funct7b5 & op[5]
  - 001: sll 0111
  - 010: slt 0101
  - 011: sltu 0110
  - 100: xor 0100
  - 101: srl 1000; sra 1001 when funct7b5
  - 110: or 0011
  - 111: and 0010
- ALUOp add -> 0000; ALUOp sub -> 0001.
- Codes 0000, 0001, 0010, 0011 and 0101 match the legacy 3-bit ALU encoding.
- imm_src combinational from op:
  - lw, I-ALU -> 00; sw -> 01; branch -> 10; jal -> 11; otherwise 00.
- No latches: every output is assigned in every branch.

Test Plan:
- Reset mid-MEMWRITE with mem_ready=0 -> async return: state_o=0, mem_write=0 immediately, illegal=0.
- lw (op 0000011), WAIT_MEM=1, mem_ready low for 3 cycles in FETCH and MEMREAD:
  - state sequence 0,0,0,0,1,2,3,3,3,3,4,0
  - ir_write pulses once; reg_write=1 only in state 4.
- R-type sub (funct3 000, funct7b5=1) -> alu_control=0001 in EXECR; addi with funct7b5=1 -> 0000.
- srai (op 0010011, funct3 101, funct7b5=1) -> 1001; with SUPPORT_SHIFTS=0 -> TRAP, illegal=1 held until rst_n low.
- bne (funct3 001), zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0; beq gives the inverse.
- op 1111111 -> DECODE->TRAP; all enables 0 for 10 following cycles; state_o=11.
